rca_arbiter: RTL

- Shares one combinational ripple-carry adder among N requesters.
- Each requester uses a valid/ready request channel (a, b, cin) and a valid/ready response channel (res, cout).
- Round-robin grant; operands are registered and held on the RCA inputs for a settle window, then the result is captured and returned.
- Sits between the requester blocks and the rca_port modport of the adder interface.

---
 rtl/rca_arb_pkg.sv | 31 +++
 rtl/rca_arbiter_rr.sv | 26 ++
 rtl/rca_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rca_arb_pkg.sv
// Shared types and helpers for the round-robin ripple-carry-adder arbiter.
// Holds the FSM encoding, statistics width and the round-robin search function.
package rca_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int STAT_W  = 16;
   localparam int MAX_REQ = 8;

   // First set bit of mask searching upward from last+1 with wrap at n.
   // Returns last unchanged when mask is empty; callers qualify with |mask.
   function automatic logic [2:0] next_rr(input logic [2:0]         last,
                                          input logic [MAX_REQ-1:0] mask,
                                          input int                 n);
      logic [2:0] pick;
      logic [2:0] idx;
      pick = last;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= n) begin
            idx = 3'((int'(last) + k) % n);
            if (mask[idx]) pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rca_arbiter_rr.sv
// Combinational round-robin pick: one-hot grant and index of the first
// requester after i_last (with wrap) whose request bit is set.
module rr_arbiter
   import rca_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = 2
)(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_last,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IW-1:0]    o_idx,
   output logic             o_any
);

   logic [MAX_REQ-1:0] w_mask;

   always_comb begin
      w_mask             = '0;
      w_mask[N_REQ-1:0]  = i_req;
      o_any              = |i_req;
      o_idx              = IW'(next_rr(3'(i_last), w_mask, N_REQ));
      o_gnt              = o_any ? (N_REQ'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/rca_arbiter.sv
// Round-robin arbiter sharing one external ripple-carry adder among N_REQ requesters.
// Optional per-requester grant counters are built when RCA_ARB_STATS_EN is defined.
module rca_arbiter
   import rca_arb_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int N_REQ   = 4,
   parameter int RCA_LAT = 1
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DWIDTH-1:0]   req_a,
   input  logic [N_REQ*DWIDTH-1:0]   req_b,
   input  logic [N_REQ-1:0]          req_cin,
   output logic [N_REQ-1:0]          resp_valid,
   input  logic [N_REQ-1:0]          resp_ready,
   output logic [DWIDTH-1:0]         resp_res,
   output logic                      resp_cout,
   output logic [$clog2(N_REQ)-1:0]  resp_id,
   output logic [DWIDTH-1:0]         rca_a,
   output logic [DWIDTH-1:0]         rca_b,
   output logic                      rca_cin,
   output logic [1:0]                dbg_state,
   input  logic [DWIDTH-1:0]         rca_res,
   input  logic                      rca_cout
`ifdef RCA_ARB_STATS_EN
   ,
   input  logic                      stat_clr,
   output logic [N_REQ*STAT_W-1:0]   stat_grant_cnt
`endif
);

   localparam int IW = $clog2(N_REQ);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, ready may depend on valid.
   arb_state_t          r_state;
   arb_state_t          w_next;
   logic [IW-1:0]       r_last;
   logic [IW-1:0]       r_gid;
   logic [3:0]          r_cnt;
   logic [DWIDTH-1:0]   r_a;
   logic [DWIDTH-1:0]   r_b;
   logic                r_cin;
   logic [DWIDTH-1:0]   r_res;
   logic                r_cout;
   logic [IW-1:0]       r_id;

   logic [N_REQ-1:0]    w_gnt;
   logic [IW-1:0]       w_idx;
   logic                w_any;
   logic                w_accept;
   logic                w_resp_hs;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr (
      .i_req  (req_valid),
      .i_last (r_last),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   always_comb begin
      w_next     = r_state;
      req_ready  = '0;
      resp_valid = '0;
      w_accept   = 1'b0;
      w_resp_hs  = 1'b0;
      case (r_state)
         IDLE: begin
            // Gated by rst so the accept strobe is silent while reset is held.
            if (w_any && !rst) begin
               req_ready = w_gnt;
               w_accept  = 1'b1;
               w_next    = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd1) w_next = RESP;
         end
         RESP: begin
            resp_valid = N_REQ'(1) << r_gid;
            if (resp_ready[r_gid]) begin
               w_resp_hs = 1'b1;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= IW'(N_REQ - 1);
         r_gid  <= '0;
         r_cnt  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_cin  <= 1'b0;
         r_res  <= '0;
         r_cout <= 1'b0;
         r_id   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a   <= req_a[w_idx*DWIDTH +: DWIDTH];
                  r_b   <= req_b[w_idx*DWIDTH +: DWIDTH];
                  r_cin <= req_cin[w_idx];
                  r_gid <= w_idx;
                  r_cnt <= 4'(RCA_LAT);
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_res  <= rca_res;
                  r_cout <= rca_cout;
                  r_id   <= r_gid;
               end
            end
            RESP: begin
               if (w_resp_hs) r_last <= r_gid;
            end
            default: ;
         endcase
      end
   end

   assign rca_a     = r_a;
   assign rca_b     = r_b;
   assign rca_cin   = r_cin;
   assign resp_res  = r_res;
   assign resp_cout = r_cout;
   assign resp_id   = r_id;
   assign dbg_state = r_state;

`ifdef RCA_ARB_STATS_EN
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      logic [STAT_W-1:0] r_stat;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            r_stat <= '0;
         else if (stat_clr)
            r_stat <= '0;
         else if (w_accept && (w_idx == IW'(gi)) && (r_stat != '1))
            r_stat <= r_stat + STAT_W'(1);
      end
      assign stat_grant_cnt[gi*STAT_W +: STAT_W] = r_stat;
   end
`endif

endmodule
